button_click_decoder: RTL

- Input-side counterpart of the menu button renderer: converts mouse position and left-button state into one-cycle "button clicked" pulses for the PLAY, MULTI and MENU boxes.
- Uses the same box geometry and the same display enables as the drawn buttons, so a click registers only on a button that is currently visible.
- Sits between the mouse controller and the game/menu state machine, in the pixel clock domain.

---
 rtl/menu_pkg.sv | 30 +++
 rtl/box_hit.sv | 29 ++
 rtl/button_click_decoder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/menu_pkg.sv
// Shared menu constants: button ids, click-decoder FSM encoding and the default
// box geometry used by both the renderer and the click decoder.
package menu_pkg;

  typedef logic [1:0] btn_id_t;

  localparam btn_id_t BTN_NONE  = 2'd0;
  localparam btn_id_t BTN_PLAY  = 2'd1;
  localparam btn_id_t BTN_MULTI = 2'd2;
  localparam btn_id_t BTN_MENU  = 2'd3;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_ARMED        = 2'd1;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd2;
  localparam logic [1:0] ST_LOCKOUT      = 2'd3;

  localparam int DEF_PLAY_BOX_X_POS   = 432;
  localparam int DEF_PLAY_BOX_Y_POS   = 400;
  localparam int DEF_PLAY_BOX_X_SIZE  = 128;
  localparam int DEF_PLAY_BOX_Y_SIZE  = 80;
  localparam int DEF_MULTI_BOX_X_POS  = 432;
  localparam int DEF_MULTI_BOX_Y_POS  = 640;
  localparam int DEF_MULTI_BOX_X_SIZE = 128;
  localparam int DEF_MULTI_BOX_Y_SIZE = 80;
  localparam int DEF_MENU_BOX_X_POS   = 432;
  localparam int DEF_MENU_BOX_Y_POS   = 520;
  localparam int DEF_MENU_BOX_X_SIZE  = 128;
  localparam int DEF_MENU_BOX_Y_SIZE  = 80;

endpackage

// File: rtl/box_hit.sv
// Combinational point-in-rectangle test gated by the box's display enable.
module box_hit #(
  parameter int X_POS  = 0,
  parameter int Y_POS  = 0,
  parameter int X_SIZE = 1,
  parameter int Y_SIZE = 1
) (
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        enable,
  output logic        hit
);

  // 13-bit compares so the far edge cannot wrap
  localparam logic [12:0] X_LO = 13'(X_POS);
  localparam logic [12:0] X_HI = 13'(X_POS + X_SIZE);
  localparam logic [12:0] Y_LO = 13'(Y_POS);
  localparam logic [12:0] Y_HI = 13'(Y_POS + Y_SIZE);

  logic [12:0] x_ext;
  logic [12:0] y_ext;

  assign x_ext = {1'b0, xpos};
  assign y_ext = {1'b0, ypos};

  assign hit = enable && (x_ext >= X_LO) && (x_ext < X_HI) &&
               (y_ext >= Y_LO) && (y_ext < Y_HI);

endmodule

// File: rtl/button_click_decoder.sv
// Turns mouse position and left-button level into one-cycle click pulses for
// the visible PLAY, MULTI and MENU buttons.
module button_click_decoder
  import menu_pkg::*;
#(
  parameter int PLAY_BOX_X_POS   = DEF_PLAY_BOX_X_POS,
  parameter int PLAY_BOX_Y_POS   = DEF_PLAY_BOX_Y_POS,
  parameter int PLAY_BOX_X_SIZE  = DEF_PLAY_BOX_X_SIZE,
  parameter int PLAY_BOX_Y_SIZE  = DEF_PLAY_BOX_Y_SIZE,
  parameter int MULTI_BOX_X_POS  = DEF_MULTI_BOX_X_POS,
  parameter int MULTI_BOX_Y_POS  = DEF_MULTI_BOX_Y_POS,
  parameter int MULTI_BOX_X_SIZE = DEF_MULTI_BOX_X_SIZE,
  parameter int MULTI_BOX_Y_SIZE = DEF_MULTI_BOX_Y_SIZE,
  parameter int MENU_BOX_X_POS   = DEF_MENU_BOX_X_POS,
  parameter int MENU_BOX_Y_POS   = DEF_MENU_BOX_Y_POS,
  parameter int MENU_BOX_X_SIZE  = DEF_MENU_BOX_X_SIZE,
  parameter int MENU_BOX_Y_SIZE  = DEF_MENU_BOX_Y_SIZE,
  parameter int LOCKOUT_CYCLES   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        mouse_left,
  input  logic        display_buttons_m_and_s,
  input  logic        display_menu_button,
  output logic        play_clicked,
  output logic        multi_clicked,
  output logic        menu_clicked,
  output logic [1:0]  hover_id,
  output logic        button_held
);

  logic    play_hit, multi_hit, menu_hit;
  btn_id_t hit_id_p0;
  logic    mouse_left_q;
  logic    press_edge, release_edge, armed_en;

  logic [1:0]  state_q, state_d;
  btn_id_t     armed_q, armed_d, click_d;
  logic [15:0] lock_q, lock_d;

  box_hit #(.X_POS(PLAY_BOX_X_POS), .Y_POS(PLAY_BOX_Y_POS),
            .X_SIZE(PLAY_BOX_X_SIZE), .Y_SIZE(PLAY_BOX_Y_SIZE)) u_play_hit (
    .xpos(xpos), .ypos(ypos), .enable(display_buttons_m_and_s), .hit(play_hit));

  box_hit #(.X_POS(MULTI_BOX_X_POS), .Y_POS(MULTI_BOX_Y_POS),
            .X_SIZE(MULTI_BOX_X_SIZE), .Y_SIZE(MULTI_BOX_Y_SIZE)) u_multi_hit (
    .xpos(xpos), .ypos(ypos), .enable(display_buttons_m_and_s), .hit(multi_hit));

  box_hit #(.X_POS(MENU_BOX_X_POS), .Y_POS(MENU_BOX_Y_POS),
            .X_SIZE(MENU_BOX_X_SIZE), .Y_SIZE(MENU_BOX_Y_SIZE)) u_menu_hit (
    .xpos(xpos), .ypos(ypos), .enable(display_menu_button), .hit(menu_hit));

  // Overlap priority: PLAY, then MENU, then MULTI
  always_comb begin
    hit_id_p0 = BTN_NONE;
    if (play_hit)       hit_id_p0 = BTN_PLAY;
    else if (menu_hit)  hit_id_p0 = BTN_MENU;
    else if (multi_hit) hit_id_p0 = BTN_MULTI;
  end

  assign press_edge   = mouse_left & ~mouse_left_q;
  assign release_edge = ~mouse_left & mouse_left_q;
  assign armed_en     = (armed_q == BTN_MENU) ? display_menu_button : display_buttons_m_and_s;
  assign button_held  = (state_q == ST_ARMED);

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    lock_d  = lock_q;
    click_d = BTN_NONE;
    case (state_q)
      ST_IDLE: begin
        if (press_edge && hit_id_p0 != BTN_NONE) begin
          state_d = ST_ARMED;
          armed_d = hit_id_p0;
        end else if (mouse_left) begin
          state_d = ST_WAIT_RELEASE;
        end
      end
      ST_ARMED: begin
        // A button that vanished while held can never be clicked
        if (!armed_en) begin
          state_d = ST_WAIT_RELEASE;
          armed_d = BTN_NONE;
        end else if (release_edge) begin
          if (hit_id_p0 == armed_q) begin
            click_d = armed_q;
            lock_d  = 16'(LOCKOUT_CYCLES - 1);
            state_d = ST_LOCKOUT;
          end else begin
            state_d = ST_IDLE;
          end
          armed_d = BTN_NONE;
        end
      end
      ST_WAIT_RELEASE: begin
        if (!mouse_left) state_d = ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (lock_q == 16'd0) state_d = mouse_left ? ST_WAIT_RELEASE : ST_IDLE;
        else                 lock_d  = lock_q - 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset leaves mouse_left_q high so a button held through reset is not a press
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      armed_q       <= BTN_NONE;
      lock_q        <= 16'd0;
      mouse_left_q  <= 1'b1;
      hover_id      <= BTN_NONE;
      play_clicked  <= 1'b0;
      multi_clicked <= 1'b0;
      menu_clicked  <= 1'b0;
    end else begin
      state_q       <= state_d;
      armed_q       <= armed_d;
      lock_q        <= lock_d;
      mouse_left_q  <= mouse_left;
      hover_id      <= hit_id_p0;
      play_clicked  <= (click_d == BTN_PLAY);
      multi_clicked <= (click_d == BTN_MULTI);
      menu_clicked  <= (click_d == BTN_MENU);
    end
  end

endmodule
